// File: rtl/alu_result_fifo.sv
// Result-capture stage behind the 4-bit ALU: sanitises each result (div-by-zero, sub borrow)
// and buffers it in a small FIFO with valid/ready on both sides, plus a saturating dz counter.
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_a,
  input  logic [3:0]                 in_b,
  input  logic [1:0]                 in_op,
  input  logic [7:0]                 in_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_op,
  output logic [7:0]                 out_y,
  output logic                       out_dz,
  output logic                       out_neg,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 dz_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b11;

  function automatic logic div_by_zero(input logic [1:0] op, input logic [3:0] b);
    return (op == OP_DIV) && (b == 4'd0);
  endfunction

  function automatic logic sub_borrow(input logic [1:0] op, input logic [3:0] a,
                                      input logic [3:0] b);
    return (op == OP_SUB) && (a < b);
  endfunction

  // A divide by zero carries an undefined ALU result, so it is replaced outright.
  function automatic logic [7:0] sanitise_y(input logic dz, input logic [7:0] y);
    return dz ? 8'hFF : y;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [1:0]       mem_op  [DEPTH];
  logic [7:0]       mem_y   [DEPTH];
  logic             mem_dz  [DEPTH];
  logic             mem_neg [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic [7:0]       dz_cnt;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             new_dz;
  logic             new_neg;
  logic [7:0]       new_y;

  // Handshake flags come only from registered occupancy.
  always_comb begin
    full      = (occ == CNT_W'(DEPTH));
    empty     = (occ == '0);
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && !full;
    pop       = out_ready && !empty;
    new_dz    = div_by_zero(in_op, in_b);
    new_neg   = sub_borrow(in_op, in_a, in_b);
    new_y     = sanitise_y(new_dz, in_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_op[i]  <= '0;
        mem_y[i]   <= '0;
        mem_dz[i]  <= 1'b0;
        mem_neg[i] <= 1'b0;
      end
    end else if (push) begin
      mem_op[wr_ptr]  <= in_op;
      mem_y[wr_ptr]   <= new_y;
      mem_dz[wr_ptr]  <= new_dz;
      mem_neg[wr_ptr] <= new_neg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      dz_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      if (push && new_dz) begin
        dz_cnt <= sat_inc8(dz_cnt);
      end
    end
  end

  // Head entry is read straight from storage; no output register.
  always_comb begin
    out_op   = mem_op[rd_ptr];
    out_y    = mem_y[rd_ptr];
    out_dz   = mem_dz[rd_ptr];
    out_neg  = mem_neg[rd_ptr];
    count    = occ;
    dz_count = dz_cnt;
  end

endmodule
